hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, stall counter.
// Optional multi-cycle mul/div tracking FSM is enabled by defining HAZARD_MULDIV_EN.
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        use_rs_d,
  input  logic        use_rt_d,
  input  logic        md_use_d,
  input  logic [4:0]  wreg_e,
  input  logic        load_e,
  input  logic        md_start_e,
  input  logic        redirect_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic [4:0]  src [2];
  logic [1:0]  src_use;
  logic [1:0]  src_hit;
  logic        lu;
  logic        mh;
  logic        busy_raw;
  logic        done_raw;
  logic [31:0] stall_cnt_reg;

  assign src[0]  = rs_d;
  assign src[1]  = rt_d;
  assign src_use = {use_rt_d, use_rs_d};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src[gi] == wreg_e);
    end
  endgenerate

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign lu = load_e && (wreg_e != 5'd0) && (|src_hit);

`ifdef HAZARD_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t  state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (md_start_e) begin
          state_next = BUSY;
          cnt_next   = 8'(MD_LAT - 1);
        end
      end
      BUSY: begin
        // Starts while busy are blocked upstream by the decode stall.
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = DONE;
      end
      DONE: begin
        if (md_start_e) begin
          state_next = BUSY;
          cnt_next   = 8'(MD_LAT - 1);
        end else begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign busy_raw = (state_reg == BUSY);
  assign done_raw = (state_reg == DONE);
  // Result is forwarded in DONE, so only BUSY holds back hi/lo readers.
  assign mh       = md_use_d && busy_raw;
`else
  logic       unused_md;
  logic [7:0] unused_lat;

  assign unused_md  = md_use_d ^ md_start_e;
  assign unused_lat = 8'(MD_LAT);
  assign busy_raw   = 1'b0;
  assign done_raw   = 1'b0;
  assign mh         = 1'b0;
`endif

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      if (redirect_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu || mh) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign md_busy = !rst && busy_raw;
  assign md_done = !rst && done_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= 32'd0;
    end else if (stall_d) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule
